// File: rtl/pseudorange_gen_pkg.sv
// ============================================================================
// pseudorange_gen_pkg : widths, FSM encoding and bias saturation helper
// Revision: 1.0
// ============================================================================
`default_nettype none

package pseudorange_gen_pkg;

  localparam int COORD_W     = 30;
  localparam int RANGE_W     = 32;
  localparam int SAT_N       = 4;
  localparam int CYC_PER_SAT = 37;
  localparam int DIFF_W      = COORD_W + 1;
  localparam int SQ_W        = 2 * DIFF_W;
  localparam int ACC_W       = 64;
  localparam int ROOT_CYC    = 32;

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    DIFF  = 4'd1,
    SQ    = 4'd2,
    ROOT  = 4'd3,
    STORE = 4'd4,
    DONE  = 4'd5
  } state_t;

  // Signed bias added to an unsigned range, clamped to [0, 2^RANGE_W-1].
  function automatic logic [RANGE_W-1:0] sat_add_bias(
    input logic [RANGE_W-1:0] geo,
    input logic [RANGE_W-1:0] bias
  );
    logic [RANGE_W+1:0] s;
    s = {2'b00, geo} + {{2{bias[RANGE_W-1]}}, bias};
    if (s[RANGE_W+1])
      return '0;
    else if (s[RANGE_W])
      return '1;
    else
      return s[RANGE_W-1:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/isqrt_serial.sv
// ============================================================================
// isqrt_serial : bit-serial floor square root, 64-bit radicand, one root bit
//                per cycle, 32 cycles from start to valid.
// Revision: 1.0
// ============================================================================
`default_nettype none

module isqrt_serial
  import pseudorange_gen_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [ACC_W-1:0]   radicand,
  output logic               busy,
  output logic               valid,
  output logic [RANGE_W-1:0] root
);

  localparam int REM_W = RANGE_W + 4;

  logic [ACC_W-1:0]   rad_q, rad_d;
  logic [REM_W-1:0]   rem_q, rem_d;
  logic [RANGE_W-1:0] root_q, root_d;
  logic [4:0]         cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               valid_q, valid_d;
  logic [REM_W-1:0]   shift_w, trial_w;

  // Remainder never exceeds 2*root, so its top two bits can be dropped on shift.
  assign shift_w = {rem_q[REM_W-3:0], rad_q[ACC_W-1 -: 2]};
  assign trial_w = {2'b00, root_q, 2'b01};

  always_comb begin
    rad_d   = rad_q;
    rem_d   = rem_q;
    root_d  = root_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    valid_d = 1'b0;
    if (start) begin
      rad_d  = radicand;
      rem_d  = '0;
      root_d = '0;
      cnt_d  = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      rad_d = rad_q << 2;
      if (shift_w >= trial_w) begin
        rem_d  = shift_w - trial_w;
        root_d = {root_q[RANGE_W-2:0], 1'b1};
      end else begin
        rem_d  = shift_w;
        root_d = {root_q[RANGE_W-2:0], 1'b0};
      end
      cnt_d = cnt_q + 5'd1;
      if (cnt_q == 5'(ROOT_CYC - 1)) begin
        busy_d  = 1'b0;
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rad_q   <= '0;
      rem_q   <= '0;
      root_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      rad_q   <= rad_d;
      rem_q   <= rem_d;
      root_q  <= root_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
    end
  end

  assign busy  = busy_q;
  assign valid = valid_q;
  assign root  = root_q;

endmodule

`default_nettype wire

// File: rtl/pseudorange_gen.sv
// ============================================================================
// pseudorange_gen : sequential geometric range to four satellites, 37 cycles
//                   per satellite. Optional clock bias: PSEUDORANGE_CLOCK_BIAS_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module pseudorange_gen
  import pseudorange_gen_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [COORD_W-1:0] c1, c2, c3,
  input  logic [COORD_W-1:0] x1, x2, x3, x4,
  input  logic [COORD_W-1:0] y1, y2, y3, y4,
  input  logic [COORD_W-1:0] z1, z2, z3, z4,
  output logic [RANGE_W-1:0] r1, r2, r3, r4,
  output logic               done,
  output logic [3:0]         state
`ifdef PSEUDORANGE_CLOCK_BIAS_EN
  ,
  input  logic [RANGE_W-1:0] bias
`endif
);

  state_t             state_q, state_d;
  logic [1:0]         idx_q, idx_d;
  logic [4:0]         cnt_q, cnt_d;
  logic               cap_w, start_w, store_w;

  logic [COORD_W-1:0] cx_q, cy_q, cz_q;
  logic [COORD_W-1:0] sx_q [SAT_N];
  logic [COORD_W-1:0] sy_q [SAT_N];
  logic [COORD_W-1:0] sz_q [SAT_N];
  logic [DIFF_W-1:0]  dx_q, dy_q, dz_q;
  logic [ACC_W-1:0]   acc_q;
  logic [RANGE_W-1:0] r_q [SAT_N];

  logic [DIFF_W-1:0]  op_w;
  logic [SQ_W-1:0]    op_ext_w, prod_w;
  logic [ACC_W-1:0]   sum_w;
  logic               sq_busy, sq_valid;
  logic [RANGE_W-1:0] sq_root, range_w;

`ifdef PSEUDORANGE_CLOCK_BIAS_EN
  logic [RANGE_W-1:0] bias_q;
  assign range_w = sat_add_bias(sq_root, bias_q);
`else
  assign range_w = sq_root;
`endif

  // One shared multiplier squares one axis per SQ cycle.
  assign op_w     = (cnt_q == 5'd0) ? dx_q : (cnt_q == 5'd1) ? dy_q : dz_q;
  assign op_ext_w = {{DIFF_W{op_w[DIFF_W-1]}}, op_w};
  assign prod_w   = op_ext_w * op_ext_w;
  assign sum_w    = acc_q + {{(ACC_W-SQ_W){1'b0}}, prod_w};

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    cap_w   = 1'b0;
    start_w = 1'b0;
    store_w = 1'b0;
    case (state_q)
      IDLE: begin
        if (en) begin
          cap_w   = 1'b1;
          idx_d   = 2'd0;
          state_d = DIFF;
        end
      end
      DIFF: begin
        cnt_d   = 5'd0;
        state_d = SQ;
      end
      SQ: begin
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd2) begin
          start_w = !sq_busy;
          cnt_d   = 5'd0;
          state_d = ROOT;
        end
      end
      ROOT: begin
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'(ROOT_CYC - 1))
          state_d = STORE;
      end
      STORE: begin
        store_w = sq_valid;
        if (idx_q == 2'(SAT_N - 1)) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + 2'd1;
          state_d = DIFF;
        end
      end
      DONE: begin
        if (!en)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cx_q  <= '0;
      cy_q  <= '0;
      cz_q  <= '0;
      dx_q  <= '0;
      dy_q  <= '0;
      dz_q  <= '0;
      acc_q <= '0;
      for (int i = 0; i < SAT_N; i++) begin
        sx_q[i] <= '0;
        sy_q[i] <= '0;
        sz_q[i] <= '0;
        r_q[i]  <= '0;
      end
`ifdef PSEUDORANGE_CLOCK_BIAS_EN
      bias_q <= '0;
`endif
    end else begin
      if (cap_w) begin
        cx_q <= c1;
        cy_q <= c2;
        cz_q <= c3;
        sx_q[0] <= x1; sx_q[1] <= x2; sx_q[2] <= x3; sx_q[3] <= x4;
        sy_q[0] <= y1; sy_q[1] <= y2; sy_q[2] <= y3; sy_q[3] <= y4;
        sz_q[0] <= z1; sz_q[1] <= z2; sz_q[2] <= z3; sz_q[3] <= z4;
`ifdef PSEUDORANGE_CLOCK_BIAS_EN
        bias_q <= bias;
`endif
      end
      if (state_q == DIFF) begin
        dx_q <= {sx_q[idx_q][COORD_W-1], sx_q[idx_q]} - {cx_q[COORD_W-1], cx_q};
        dy_q <= {sy_q[idx_q][COORD_W-1], sy_q[idx_q]} - {cy_q[COORD_W-1], cy_q};
        dz_q <= {sz_q[idx_q][COORD_W-1], sz_q[idx_q]} - {cz_q[COORD_W-1], cz_q};
      end
      if (state_q == SQ)
        acc_q <= (cnt_q == 5'd0) ? {{(ACC_W-SQ_W){1'b0}}, prod_w} : sum_w;
      if (store_w)
        r_q[idx_q] <= range_w;
    end
  end

  // Radicand is the accumulator plus the z-axis square still on the multiplier.
  isqrt_serial u_isqrt (
    .clk      (clk),
    .rst      (rst),
    .start    (start_w),
    .radicand (sum_w),
    .busy     (sq_busy),
    .valid    (sq_valid),
    .root     (sq_root)
  );

  assign r1    = r_q[0];
  assign r2    = r_q[1];
  assign r3    = r_q[2];
  assign r4    = r_q[3];
  assign done  = (state_q == DONE);
  assign state = state_q;

endmodule

`default_nettype wire

// File: doc/pseudorange_gen.md
PSEUDORANGE_GEN -- requirements
Module: pseudorange_gen

Interface
REQ-001 SHALL expose: clk  input  1  single system clock, all state on rising edge.
REQ-002 SHALL expose: rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL expose: en  input  1  level start request, sampled in IDLE.
REQ-004 SHALL expose: c1,c2,c3  input  30 each  signed receiver position, metres.
REQ-005 SHALL expose: x1..x4, y1..y4, z1..z4  input  30 each  signed satellite positions, metres.
REQ-006 SHALL expose: r1..r4  output  32 each  unsigned range per satellite, metres.
REQ-007 SHALL expose: done  output  1  results valid (level).
REQ-008 SHALL expose: state  output  4  current FSM state encoding.

Function
REQ-009 Each range SHALL be floor(sqrt((xi-c1)^2+(yi-c2)^2+(zi-c3)^2)): 31-bit signed differences, 62-bit squares, 64-bit unsigned sum, exact, no overflow.
REQ-010 FSM states and state encodings SHALL be IDLE=0, DIFF=1, SQ=2, ROOT=3, STORE=4, DONE=5.
REQ-011 In IDLE with en=1 at an edge, all 15 coordinate inputs SHALL be captured, satellite index set to 1, next state DIFF; input changes afterwards SHALL NOT affect results.
REQ-012 Per satellite: DIFF 1 cycle, SQ 3 cycles (one shared multiplier, one axis per cycle, accumulate), ROOT 32 cycles (one result bit per cycle), STORE 1 cycle writing ri = 37 cycles.
REQ-013 STORE SHALL go to DIFF for the next index, or DONE after index 4; done SHALL be high exactly 148 edges after the capture edge.
REQ-014 In DONE, done SHALL stay high while en=1; en=0 SHALL return to IDLE with done=0 on that edge.
REQ-015 r1..r4 SHALL hold last results until overwritten by the next run's STORE; en is ignored outside IDLE/DONE.
REQ-016 A coincident satellite/receiver SHALL yield ri=0.

Reset
REQ-017 rst=1 SHALL immediately force state=IDLE, done=0, r1..r4=0, clear all internal registers, independent of clk.
REQ-018 Reset mid-run SHALL abort without a done pulse; if en=1 after release, a new capture SHALL occur at the first edge in IDLE.

Configuration
REQ-019 With PSEUDORANGE_CLOCK_BIAS_EN defined, port bias (input, 32, signed metres) SHALL be added in STORE with saturation to 0 and 2^32-1, and be captured with the coordinates.
REQ-020 Without PSEUDORANGE_CLOCK_BIAS_EN, bias port and adder SHALL be absent and ranges purely geometric, with identical latency.

Structure
REQ-021 A shared package SHALL hold COORD_W=30, RANGE_W=32, SAT_N=4, CYC_PER_SAT=37 and the state enum/encodings.
REQ-022 The bit-serial square root SHALL be sub-module isqrt_serial (64-bit radicand, 32-bit root, start/busy/valid, 32 cycles).

Verification
REQ-023 Receiver (0,0,0); sats (3,4,0),(0,0,-12),(1,1,1),(0,0,0) -> r1=5, r2=12, r3=1, r4=0; done high 148 edges after capture.
REQ-024 Receiver (-2^29,-2^29,-2^29), sat1 (2^29-1,2^29-1,2^29-1) -> r1=1859775391, no overflow.
REQ-025 rst asserted 50 cycles after capture -> state=0, done=0, r1..r4=0 immediately, no done pulse; en held high -> fresh capture on first post-reset edge, correct results 148 edges later.
REQ-026 Inputs changed every cycle during a run -> results match captured values; en held after done -> done and ri stable; en=0 -> state=0, done=0 next edge, ri retained.
REQ-027 With PSEUDORANGE_CLOCK_BIAS_EN, geometry giving 5: bias=-10 -> 0, bias=+7 -> 12; geometry giving 2^32-2 with bias=+5 -> 4294967295.
